// File: rtl/vector_cache_pkg.sv
// Shared types and default parameters for the vector cache data RAM arbiter.
//   DEF_*              : default parameter values used by the arbiter, its
//                        interface and its sub-module
//   arb_mode_e         : arbitration policy selector
//   dataram_arb_req_t  : one requestor's request bundle (default widths)
//   dataram_arb_rsp_t  : one requestor's read response (default widths)
//   idx_w()            : width of an index into n items (at least 1 bit)
package vector_cache_pkg;

    localparam int DEF_REQ_NUM   = 4;
    localparam int DEF_BANK_NUM  = 4;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 256;
    localparam int DEF_RAM_LAT   = 2;
    localparam int DEF_STARVE_TH = 15;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } dataram_arb_req_t;

    typedef struct packed {
        logic                  vld;
        logic [DEF_DATA_W-1:0] data;
    } dataram_arb_rsp_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dataram_bank_arb_if.sv
// Requestor-side bus of the data RAM bank arbiter.
//   arb_mode  : 0 fixed priority, 1 round-robin
//   req_*     : per-requestor request (vld/wr/addr/wdata) and combinational rdy
//   rsp_*     : per-requestor read response, data zero when not valid
//   starved   : per-requestor starvation flag
// master = requestor side, slave = arbiter side.
interface dataram_bank_arb_if
    import vector_cache_pkg::*;
#(
    parameter int REQ_NUM = DEF_REQ_NUM,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic                             arb_mode;
    logic [REQ_NUM-1:0]               req_vld;
    logic [REQ_NUM-1:0]               req_wr;
    logic [REQ_NUM-1:0][ADDR_W-1:0]   req_addr;
    logic [REQ_NUM-1:0][DATA_W-1:0]   req_wdata;
    logic [REQ_NUM-1:0]               req_rdy;
    logic [REQ_NUM-1:0]               rsp_vld;
    logic [REQ_NUM-1:0][DATA_W-1:0]   rsp_data;
    logic [REQ_NUM-1:0]               starved;

    modport master (
        output arb_mode, req_vld, req_wr, req_addr, req_wdata,
        input  req_rdy, rsp_vld, rsp_data, starved
    );

    modport slave (
        input  arb_mode, req_vld, req_wr, req_addr, req_wdata,
        output req_rdy, rsp_vld, rsp_data, starved
    );

endinterface

// File: rtl/dataram_bank_rr_arb.sv
// Single-bank arbiter: starved requestors first (lowest index), otherwise
// fixed priority or round-robin from a per-bank pointer.
//   clk, rst  : clock, async active-high reset
//   arb_mode  : 0 fixed, 1 round-robin (sampled every cycle)
//   req       : requestors targeting this bank
//   starved   : starvation flags of all requestors
//   gnt       : one-hot grant
//   gnt_vld   : a grant was issued
//   gnt_idx   : index of the grantee
module dataram_bank_rr_arb
    import vector_cache_pkg::*;
#(
    parameter  int REQ_NUM = DEF_REQ_NUM,
    localparam int IDX_W   = idx_w(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_mode,
    input  logic [REQ_NUM-1:0] req,
    input  logic [REQ_NUM-1:0] starved,
    output logic [REQ_NUM-1:0] gnt,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_NUM-1:0] stv_req;

    // Loops run from high to low so the last hit, i.e. the lowest
    // index (or closest to the pointer), is the one left standing.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] sel;
        j       = 0;
        sel     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        ptr_d   = ptr_q;
        stv_req = req & starved;
        if (|stv_req) begin
            for (int i = REQ_NUM - 1; i >= 0; i--)
                if (stv_req[i]) gnt_idx = IDX_W'(i);
            gnt_vld = 1'b1;
        end else if (arb_mode == ARB_FIXED) begin
            for (int i = REQ_NUM - 1; i >= 0; i--)
                if (req[i]) gnt_idx = IDX_W'(i);
            gnt_vld = |req;
        end else begin
            for (int k = REQ_NUM - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= REQ_NUM) j = j - REQ_NUM;
                sel = IDX_W'(j);
                if (req[sel]) gnt_idx = sel;
            end
            gnt_vld = |req;
        end
        // Pointer only moves on round-robin cycles so that a stretch of
        // fixed-priority operation leaves it where RR last put it.
        if (arb_mode == ARB_RR && gnt_vld)
            ptr_d = (int'(gnt_idx) == REQ_NUM - 1) ? '0 : gnt_idx + 1'b1;
        gnt = gnt_vld ? (REQ_NUM'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dataram_bank_arb.sv
// Data RAM bank arbiter: REQ_NUM requestors share BANK_NUM independently
// arbitrated RAM banks (bank = addr[BANK_W-1:0]). Granted requests drive
// the bank from registers one cycle later; read data is routed back to the
// requestor RAM_LAT cycles after that through a per-bank tag pipeline.
//   clk, rst   : clock, async active-high reset
//   bus        : requestor-side interface (slave modport)
//   ram_en/wr  : per-bank RAM strobe / write enable
//   ram_addr   : per-bank word address addr[ADDR_W-1:BANK_W]
//   ram_wdata  : per-bank write data
//   ram_rdata  : per-bank read data, valid RAM_LAT cycles after ram_en
module dataram_bank_arb
    import vector_cache_pkg::*;
#(
    parameter  int REQ_NUM   = DEF_REQ_NUM,
    parameter  int BANK_NUM  = DEF_BANK_NUM,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int RAM_LAT   = DEF_RAM_LAT,
    parameter  int STARVE_TH = DEF_STARVE_TH,
    localparam int BANK_W    = $clog2(BANK_NUM),
    localparam int RA_W      = ADDR_W - BANK_W
) (
    input  logic                             clk,
    input  logic                             rst,
    dataram_bank_arb_if.slave                bus,
    output logic [BANK_NUM-1:0]              ram_en,
    output logic [BANK_NUM-1:0]              ram_wr,
    output logic [BANK_NUM-1:0][RA_W-1:0]    ram_addr,
    output logic [BANK_NUM-1:0][DATA_W-1:0]  ram_wdata,
    input  logic [BANK_NUM-1:0][DATA_W-1:0]  ram_rdata
);

    localparam int IDX_W = idx_w(REQ_NUM);
    localparam int CNT_W = $clog2(STARVE_TH + 1);

    logic [BANK_NUM-1:0][REQ_NUM-1:0]          bank_req, bank_gnt;
    logic [BANK_NUM-1:0]                       gnt_vld;
    logic [BANK_NUM-1:0][IDX_W-1:0]            gnt_idx;
    logic [REQ_NUM-1:0]                        rdy, starved;
    logic [REQ_NUM-1:0][CNT_W-1:0]             wait_cnt_q, wait_cnt_d;

    logic [BANK_NUM-1:0]                       ram_en_q, ram_en_d, ram_wr_q, ram_wr_d;
    logic [BANK_NUM-1:0][RA_W-1:0]             ram_addr_q, ram_addr_d;
    logic [BANK_NUM-1:0][DATA_W-1:0]           ram_wdata_q, ram_wdata_d;

    // Read tag pipeline: stage 0 lines up with ram_en, stage RAM_LAT with rdata.
    logic [BANK_NUM-1:0][RAM_LAT:0]            vld_pipe_q, vld_pipe_d;
    logic [BANK_NUM-1:0][RAM_LAT:0][IDX_W-1:0] idx_pipe_q, idx_pipe_d;

    logic [REQ_NUM-1:0]                        rsp_vld;
    logic [REQ_NUM-1:0][DATA_W-1:0]            rsp_data;

    // Requests are masked during reset so nothing is granted and no
    // pointer moves while rst is held.
    always_comb begin
        bank_req = '0;
        for (int b = 0; b < BANK_NUM; b++)
            for (int i = 0; i < REQ_NUM; i++)
                bank_req[b][i] = !rst && bus.req_vld[i] &&
                                 (bus.req_addr[i][BANK_W-1:0] == BANK_W'(b));
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        dataram_bank_rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
            .clk     (clk),
            .rst     (rst),
            .arb_mode(bus.arb_mode),
            .req     (bank_req[b]),
            .starved (starved),
            .gnt     (bank_gnt[b]),
            .gnt_vld (gnt_vld[b]),
            .gnt_idx (gnt_idx[b])
        );
    end

    always_comb begin
        rdy = '0;
        for (int b = 0; b < BANK_NUM; b++) rdy = rdy | bank_gnt[b];
    end

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            starved[i] = (wait_cnt_q[i] == CNT_W'(STARVE_TH));
            if (!bus.req_vld[i] || rdy[i])  wait_cnt_d[i] = '0;
            else if (starved[i])            wait_cnt_d[i] = wait_cnt_q[i];
            else                            wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
        end
    end

    // Bank command and read-tag capture from this cycle's grants.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            ram_en_d[b]       = gnt_vld[b];
            ram_wr_d[b]       = gnt_vld[b] && bus.req_wr[gnt_idx[b]];
            ram_addr_d[b]     = gnt_vld[b] ? bus.req_addr[gnt_idx[b]][ADDR_W-1:BANK_W]
                                           : ram_addr_q[b];
            ram_wdata_d[b]    = gnt_vld[b] ? bus.req_wdata[gnt_idx[b]] : ram_wdata_q[b];
            vld_pipe_d[b][0]  = gnt_vld[b] && !bus.req_wr[gnt_idx[b]];
            idx_pipe_d[b][0]  = gnt_idx[b];
            for (int k = RAM_LAT; k >= 1; k--) begin
                vld_pipe_d[b][k] = vld_pipe_q[b][k-1];
                idx_pipe_d[b][k] = idx_pipe_q[b][k-1];
            end
        end
    end

    // A requestor has at most one grant per cycle, so two banks never
    // complete for the same requestor in the same cycle.
    always_comb begin
        rsp_vld  = '0;
        rsp_data = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (vld_pipe_q[b][RAM_LAT]) begin
                rsp_vld[idx_pipe_q[b][RAM_LAT]]  = 1'b1;
                rsp_data[idx_pipe_q[b][RAM_LAT]] = ram_rdata[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            ram_en_q    <= '0;
            ram_wr_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            vld_pipe_q  <= '0;
            idx_pipe_q  <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            ram_en_q    <= ram_en_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            vld_pipe_q  <= vld_pipe_d;
            idx_pipe_q  <= idx_pipe_d;
        end
    end

    assign bus.req_rdy  = rdy;
    assign bus.starved  = starved;
    assign bus.rsp_vld  = rsp_vld;
    assign bus.rsp_data = rsp_data;
    assign ram_en       = ram_en_q;
    assign ram_wr       = ram_wr_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_dataram_bank_arb.sv
// Self-checking bench for dataram_bank_arb: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_dataram_bank_arb;
    import vector_cache_pkg::*;

    localparam int RN = 4, BN = 4, AW = 12, DW = 256, LAT = 2, TH = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [BN-1:0]            ram_en, ram_wr;
    logic [BN-1:0][AW-3:0]    ram_addr;
    logic [BN-1:0][DW-1:0]    ram_wdata, ram_rdata;

    dataram_bank_arb_if #(.REQ_NUM(RN), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dataram_bank_arb #(
        .REQ_NUM(RN), .BANK_NUM(BN), .ADDR_W(AW), .DATA_W(DW),
        .RAM_LAT(LAT), .STARVE_TH(TH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // ---------------- model state ----------------
    typedef struct { int due; int req; int bank; } pend_t;
    dataram_arb_req_t rq [RN];
    logic             mode;
    int               wcnt [RN];
    int               ptr  [BN];
    logic [BN-1:0]    exp_en, exp_wr;
    logic [AW-3:0]    exp_addr [BN];
    logic [DW-1:0]    exp_wd   [BN];
    pend_t            pend[$];
    logic [RN-1:0]    last_gnt;
    int               cyc = 0, errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int bank_of(input int i);
        return int'(rq[i].addr) % BN;
    endfunction

    // Winner for bank b from the rules: starved lowest index, then policy.
    function automatic int pick(input int b);
        int s = -1;
        for (int i = 0; i < RN; i++)
            if (s < 0 && rq[i].vld && bank_of(i) == b && wcnt[i] == TH) s = i;
        if (s >= 0) return s;
        for (int k = 0; k < RN; k++) begin
            int i = mode ? (ptr[b] + k) % RN : k;
            if (s < 0 && rq[i].vld && bank_of(i) == b) s = i;
        end
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RN; i++) wcnt[i] = 0;
        for (int b = 0; b < BN; b++) begin
            ptr[b] = 0; exp_addr[b] = '0; exp_wd[b] = '0;
        end
        exp_en = '0; exp_wr = '0;
        pend.delete();
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic cycle();
        logic [RN-1:0]         e_rdy, e_stv, e_rv;
        logic [RN-1:0][DW-1:0] e_rd;
        int                    g [BN];
        bus.arb_mode = mode;
        for (int i = 0; i < RN; i++) begin
            bus.req_vld[i]   = rq[i].vld;
            bus.req_wr[i]    = rq[i].wr;
            bus.req_addr[i]  = rq[i].addr;
            bus.req_wdata[i] = rq[i].wdata;
        end
        for (int b = 0; b < BN; b++) ram_rdata[b] = {8{$urandom}};
        @(negedge clk);
        e_rdy = '0; e_stv = '0; e_rv = '0; e_rd = '0;
        for (int b = 0; b < BN; b++) g[b] = -1;
        if (rst) begin
            model_clear();
            chk("rst_ram_addr", DW'(ram_addr), '0);
            chk("rst_ram_wdata", DW'(ram_wdata), '0);
            chk("rst_ram_wr", DW'(ram_wr), '0);
        end else begin
            for (int i = 0; i < RN; i++) e_stv[i] = (wcnt[i] == TH);
            for (int b = 0; b < BN; b++) begin
                g[b] = pick(b);
                if (g[b] >= 0) e_rdy[g[b]] = 1'b1;
            end
            for (int n = pend.size() - 1; n >= 0; n--)
                if (pend[n].due == cyc) begin
                    e_rv[pend[n].req]   = 1'b1;
                    e_rd[pend[n].req]   = ram_rdata[pend[n].bank];
                    pend.delete(n);
                end
            chk("ram_wr", DW'(ram_wr & exp_en), DW'(exp_wr));
            for (int b = 0; b < BN; b++)
                if (exp_en[b]) begin
                    chk($sformatf("ram_addr[%0d]", b), DW'(ram_addr[b]), DW'(exp_addr[b]));
                    chk($sformatf("ram_wdata[%0d]", b), ram_wdata[b], exp_wd[b]);
                end
        end
        chk("req_rdy", DW'(bus.req_rdy), DW'(e_rdy));
        chk("starved", DW'(bus.starved), DW'(e_stv));
        chk("ram_en", DW'(ram_en), DW'(exp_en));
        chk("rsp_vld", DW'(bus.rsp_vld), DW'(e_rv));
        for (int i = 0; i < RN; i++)
            chk($sformatf("rsp_data[%0d]", i), bus.rsp_data[i], e_rd[i]);
        @(posedge clk);
        cyc++;
        last_gnt = e_rdy;
        if (!rst) begin
            for (int i = 0; i < RN; i++)
                if (!rq[i].vld || e_rdy[i]) wcnt[i] = 0;
                else if (wcnt[i] < TH)      wcnt[i]++;
            for (int b = 0; b < BN; b++) begin
                exp_en[b] = (g[b] >= 0);
                exp_wr[b] = 1'b0;
                if (g[b] >= 0) begin
                    exp_wr[b]   = rq[g[b]].wr;
                    exp_addr[b] = rq[g[b]].addr[AW-1:2];
                    exp_wd[b]   = rq[g[b]].wdata;
                    if (!rq[g[b]].wr) pend.push_back('{due: cyc + LAT, req: g[b], bank: b});
                    if (mode) ptr[b] = (g[b] + 1) % RN;
                end
            end
        end
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < RN; i++) rq[i] = '0;
    endtask

    task automatic set_rd(input int i, input int bank);
        rq[i].vld   = 1'b1;
        rq[i].wr    = 1'b0;
        rq[i].addr  = {AW'($urandom) >> 2, 2'(bank)};
        rq[i].wdata = {8{$urandom}};
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; last_gnt = '0;
        idle_all();
        model_clear();
        #1;
        // reset state
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // single write, bank 1, addr 0x0A5 -> word 0x029, no response
        rq[1].vld = 1'b1; rq[1].wr = 1'b1; rq[1].addr = 12'h0A5; rq[1].wdata = DW'(32'hDEAD);
        cycle();
        idle_all();
        repeat (4) cycle();

        // four reads to four banks in one cycle
        for (int i = 0; i < RN; i++) set_rd(i, i);
        cycle();
        idle_all();
        repeat (4) cycle();

        // round-robin, everyone reads bank 1 for 8 cycles
        mode = 1'b1;
        for (int i = 0; i < RN; i++) set_rd(i, 1);
        repeat (8) cycle();
        // mode 1 -> 0 -> 1 mid-stream: RR continues from retained pointer
        mode = 1'b0;
        repeat (3) cycle();
        mode = 1'b1;
        repeat (6) cycle();
        idle_all();
        repeat (4) cycle();

        // fixed priority, req 0 and 3 continuously to bank 2 -> 3 starves
        mode = 1'b0;
        set_rd(0, 2); set_rd(3, 2);
        repeat (20) cycle();
        idle_all();
        repeat (4) cycle();

        // randomized traffic, requests held until transfer
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            for (int i = 0; i < RN; i++)
                if (!rq[i].vld || last_gnt[i]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        set_rd(i, $urandom_range(0, 2));
                        rq[i].wr = ($urandom_range(0, 3) == 0);
                    end else rq[i] = '0;
                end
            cycle();
        end
        idle_all();
        repeat (4) cycle();

        // reset one cycle after a read grant discards the read
        set_rd(0, 0);
        cycle();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dataram_bank_arb.md
DATARAM_BANK_ARB -- requirements
Module: dataram_bank_arb

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4, number of requestors (0 dataram_rd, 1 dataram_wr, 2 evict_rd, 3 downstream_rxdat).
REQ-002 SHALL have parameter BANK_NUM, default 4, power of two; BANK_W = log2(BANK_NUM).
REQ-003 SHALL have parameter ADDR_W, default 12, request address width; bank select = addr[BANK_W-1:0].
REQ-004 SHALL have parameter DATA_W, default 256, data width.
REQ-005 SHALL have parameter RAM_LAT, default 2, cycles from ram_en to valid ram_rdata.
REQ-006 SHALL have parameter STARVE_TH, default 15, wait cycles before a requestor is starved.
REQ-007 SHALL have ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-008 SHALL have ports: arb_mode in 1 (0 fixed priority, 1 round-robin); req_vld in REQ_NUM; req_wr in REQ_NUM (1 write); req_addr in REQ_NUM*ADDR_W; req_wdata in REQ_NUM*DATA_W; req_rdy out REQ_NUM.
REQ-009 SHALL have ports: ram_en out BANK_NUM; ram_wr out BANK_NUM; ram_addr out BANK_NUM*(ADDR_W-BANK_W) (addr[ADDR_W-1:BANK_W]); ram_wdata out BANK_NUM*DATA_W; ram_rdata in BANK_NUM*DATA_W.
REQ-010 SHALL have ports: rsp_vld out REQ_NUM; rsp_data out REQ_NUM*DATA_W; starved out REQ_NUM.

Function
REQ-011 Transfer occurs when req_vld[i] & req_rdy[i]; requestor holds vld/wr/addr/wdata stable until transfer.
REQ-012 req_rdy SHALL be combinational: set only for the single requestor granted by its target bank this cycle.
REQ-013 Each bank SHALL grant at most one requestor per cycle among those with vld whose bank select matches; banks arbitrate independently, so up to BANK_NUM grants per cycle.
REQ-014 Priority order: starved requestors first (lowest index among starved), then arb_mode policy.
REQ-015 arb_mode=0: lowest-index requesting requestor wins.
REQ-016 arb_mode=1: per-bank pointer; first requesting index at or above pointer, wrapping past REQ_NUM-1 to 0, wins; on grant pointer <= grantee+1 modulo REQ_NUM; no grant -> pointer unchanged.
REQ-017 Pointers SHALL be retained across arb_mode changes; new mode applies to the cycle it is sampled.
REQ-018 Per-requestor wait counter: +1 each cycle vld & !rdy, saturating at STARVE_TH; cleared on transfer or vld low; starved[i] = (counter == STARVE_TH).
REQ-019 Granted transfer at cycle T SHALL drive ram_en/ram_wr/ram_addr/ram_wdata of the bank from registers in cycle T+1, one cycle only; ungranted bank ram_en=0.
REQ-020 Read transfer at T SHALL assert rsp_vld[i] for exactly one cycle at T+1+RAM_LAT, rsp_data[i] = ram_rdata of that bank in that cycle; writes produce no rsp_vld.
REQ-021 Response routing SHALL use a RAM_LAT+1 deep per-bank shift pipeline of {valid, requestor index}; one pipeline shift per cycle, so back-to-back reads from one requestor return back-to-back.
REQ-022 rsp_data[i] SHALL be zero whenever rsp_vld[i]=0.

Reset
REQ-023 While rst=1: req_rdy, ram_en, ram_wr, rsp_vld, starved = 0; ram_addr, ram_wdata, rsp_data = 0; pointers = 0; wait counters = 0.
REQ-024 Reset mid-operation SHALL discard in-flight reads; no rsp_vld for them after release.

Structure
REQ-025 dataram_arb_req_t/dataram_arb_rsp_t typedefs and default parameter constants SHALL live in vector_cache_pkg.
REQ-026 One sub-module dataram_bank_rr_arb (single-bank arbiter: starve override, fixed/RR, pointer) instantiated BANK_NUM times.

Verification
REQ-027 arb_mode=1, req 0..3 read, addr bank 1, held 8 cycles -> grants 0,1,2,3,0,1,... one per cycle; rsp_vld each 3 cycles later.
REQ-028 arb_mode=0, req 0 and 3 continuous to bank 2 -> req 0 always granted, starved[3]=1 after 15 waits, req 3 granted cycle 16, then counter clears.
REQ-029 Four reads to banks 0,1,2,3 same cycle -> all req_rdy=1; ram_en=4'b1111 next cycle; four rsp_vld at T+3.
REQ-030 Write req 1 addr 0x0A5 wdata 0xDEAD -> ram_en[1]=1, ram_wr[1]=1, ram_addr[1]=0x029 at T+1; no rsp_vld.
REQ-031 rst=1 at T+1 after read grant at T -> outputs zero immediately; no rsp_vld at T+3.
REQ-032 arb_mode toggled 1->0->1 mid-stream -> RR resumes from retained pointer value.
